// File: rtl/overlay_alpha_blender.sv
// overlay_alpha_blender
// Composites the overlay generator's RGBA stream onto the base video stream.
// The base video is delayed by OVL_LAT cycles so it lines up with the overlay,
// then goes through a 3-stage per-channel alpha blend. A frame-synchronous
// master fade scales the overlay alpha. The fade only steps on a rising edge
// of vid_vs, so a frame is never torn part-way through a ramp.
//
// Ports:
//   clk, rst_n                 pixel clock, async active-low reset
//   enable                     overlay requested on (level)
//   vid_r/g/b, vid_de/hs/vs    base video colour and syncs
//   ovl_r/g/b, ovl_alpha       overlay colour and alpha (0 transparent, 255 opaque)
//   ovl_active                 overlay pixel valid
//   out_r/g/b, out_de/hs/vs    blended colour and syncs (OVL_LAT+3 cycles later)
//   fade_level                 current master fade, 0..256
//   fade_busy                  fade is mid-ramp
module overlay_alpha_blender #(
    parameter int OVL_LAT   = 1,
    parameter int FADE_STEP = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] vid_r,
    input  logic [7:0] vid_g,
    input  logic [7:0] vid_b,
    input  logic       vid_de,
    input  logic       vid_hs,
    input  logic       vid_vs,
    input  logic [7:0] ovl_r,
    input  logic [7:0] ovl_g,
    input  logic [7:0] ovl_b,
    input  logic [7:0] ovl_alpha,
    input  logic       ovl_active,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       out_de,
    output logic       out_hs,
    output logic       out_vs,
    output logic [8:0] fade_level,
    output logic       fade_busy
);

    typedef struct packed {
        logic [2:0][7:0] rgb;   // [2]=r [1]=g [0]=b
        logic            de;
        logic            hs;
        logic            vs;
    } pix_t;

    typedef enum logic [1:0] {OFF, FADE_IN, ON, FADE_OUT} state_t;

    localparam logic [9:0] STEP = 10'(FADE_STEP);

    // ---------------- alignment delay ----------------
    pix_t vid_in, vid_al;
    assign vid_in = {vid_r, vid_g, vid_b, vid_de, vid_hs, vid_vs};

    generate
        if (OVL_LAT == 0) begin : g_nodly
            assign vid_al = vid_in;
        end else begin : g_dly
            pix_t dly_q [OVL_LAT];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < OVL_LAT; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= vid_in;
                    for (int i = 1; i < OVL_LAT; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign vid_al = dly_q[OVL_LAT-1];
        end
    endgenerate

    // ---------------- fade FSM ----------------
    state_t     state_q, state_d;
    logic [8:0] fade_q, fade_d;
    logic       vs_prev_q;
    logic       vs_rise;
    logic [9:0] fade_up, fade_dn;

    assign vs_rise = vid_vs & ~vs_prev_q;
    assign fade_up = {1'b0, fade_q} + STEP;
    assign fade_dn = {1'b0, fade_q} - STEP;

    always_comb begin
        fade_d  = fade_q;
        state_d = state_q;
        if (vs_rise) begin
            if (enable && fade_q != 9'd256)
                fade_d = (fade_up > 10'd256) ? 9'd256 : fade_up[8:0];
            else if (!enable && fade_q != 9'd0)
                fade_d = ({1'b0, fade_q} > STEP) ? fade_dn[8:0] : 9'd0;

            if (fade_d == 9'd0)        state_d = OFF;
            else if (fade_d == 9'd256) state_d = ON;
            else if (enable)           state_d = FADE_IN;
            else                       state_d = FADE_OUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OFF;
            fade_q    <= '0;
            vs_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fade_q    <= fade_d;
            vs_prev_q <= vid_vs;
        end
    end

    assign fade_level = fade_q;
    assign fade_busy  = (state_q == FADE_IN) || (state_q == FADE_OUT);

    // ---------------- S1: effective alpha ----------------
    logic [15:0]     a_prod;
    logic [7:0]      a1_d, a1_q;
    logic [2:0][7:0] ovl1_q;
    pix_t            vid1_q;

    assign a_prod = 16'(ovl_alpha) * 16'(fade_q);   // max 255*256 fits 16 bits
    assign a1_d   = (ovl_active && vid_al.de) ? a_prod[15:8] : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q   <= '0;
            ovl1_q <= '0;
            vid1_q <= '0;
        end else begin
            a1_q   <= a1_d;
            ovl1_q <= {ovl_r, ovl_g, ovl_b};
            vid1_q <= vid_al;
        end
    end

    // ---------------- S2: weighted sums ----------------
    // a_w maps 255 to 256 so an opaque overlay replaces the video exactly.
    logic [8:0]       a_w, a_inv;
    logic [2:0][16:0] sum_d, sum2_q;
    logic [2:0]       sync2_q;

    assign a_w   = {1'b0, a1_q} + 9'(a1_q[7]);
    assign a_inv = 9'd256 - a_w;

    always_comb begin
        sum_d = '0;
        for (int c = 0; c < 3; c++)
            sum_d[c] = 17'(ovl1_q[c]) * 17'(a_w) + 17'(vid1_q.rgb[c]) * 17'(a_inv) + 17'd128;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum2_q  <= '0;
            sync2_q <= '0;
        end else begin
            sum2_q  <= sum_d;
            sync2_q <= {vid1_q.de, vid1_q.hs, vid1_q.vs};
        end
    end

    // ---------------- S3: normalise, saturate, blank ----------------
    logic [2:0][7:0] out_d, out_q;
    logic [2:0]      sync3_q;

    always_comb begin
        out_d = '0;
        for (int c = 0; c < 3; c++) begin
            if (!sync2_q[2])        out_d[c] = 8'd0;
            else if (sum2_q[c][16]) out_d[c] = 8'hFF;
            else                    out_d[c] = sum2_q[c][15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            sync3_q <= '0;
        end else begin
            out_q   <= out_d;
            sync3_q <= sync2_q;
        end
    end

    assign out_r  = out_q[2];
    assign out_g  = out_q[1];
    assign out_b  = out_q[0];
    assign out_de = sync3_q[2];
    assign out_hs = sync3_q[1];
    assign out_vs = sync3_q[0];

endmodule

// File: tb/tb_overlay_alpha_blender.sv
module tb_overlay_alpha_blender;

    logic       clk, rst_n, enable;
    logic [7:0] vid_r, vid_g, vid_b;
    logic       vid_de, vid_hs, vid_vs;
    logic [7:0] ovl_r, ovl_g, ovl_b, ovl_alpha;
    logic       ovl_active;
    logic [7:0] out_r, out_g, out_b;
    logic       out_de, out_hs, out_vs;
    logic [8:0] fade_level;
    logic       fade_busy;

    // zero-latency instance for the alternate latency check
    logic [7:0] z_r, z_g, z_b;
    logic       z_de, z_hs, z_vs;
    logic [8:0] z_fade;
    logic       z_busy;

    int n_chk  = 0;
    int n_fail = 0;

    overlay_alpha_blender #(.OVL_LAT(1), .FADE_STEP(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
        .ovl_r(ovl_r), .ovl_g(ovl_g), .ovl_b(ovl_b),
        .ovl_alpha(ovl_alpha), .ovl_active(ovl_active),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs),
        .fade_level(fade_level), .fade_busy(fade_busy)
    );

    overlay_alpha_blender #(.OVL_LAT(0), .FADE_STEP(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
        .ovl_r(ovl_r), .ovl_g(ovl_g), .ovl_b(ovl_b),
        .ovl_alpha(ovl_alpha), .ovl_active(ovl_active),
        .out_r(z_r), .out_g(z_g), .out_b(z_b),
        .out_de(z_de), .out_hs(z_hs), .out_vs(z_vs),
        .fade_level(z_fade), .fade_busy(z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vs_edge();
        vid_vs = 1'b1; tick();
        vid_vs = 1'b0; tick();
    endtask

    task automatic set_pix(input logic [7:0] v, input logic [7:0] o, input logic [7:0] a);
        vid_r = v; vid_g = v; vid_b = v;
        ovl_r = o; ovl_g = o; ovl_b = o;
        ovl_alpha = a;
    endtask

    task automatic blend(input string tag, input logic [7:0] v, input logic [7:0] o,
                         input logic [7:0] a, input logic [7:0] exp);
        set_pix(v, o, a);
        tick(6);
        chk({tag, "_r"}, out_r, exp);
        chk({tag, "_g"}, out_g, exp);
        chk({tag, "_b"}, out_b, exp);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0;
        vid_de = 0; vid_hs = 0; vid_vs = 0; ovl_active = 0;
        set_pix(8'h00, 8'h00, 8'h00);

        // reset with random inputs
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            vid_r = 8'($urandom); vid_g = 8'($urandom); vid_b = 8'($urandom);
            ovl_r = 8'($urandom); ovl_alpha = 8'($urandom);
            vid_de = 1'($urandom); vid_hs = 1'($urandom); vid_vs = 1'($urandom);
            ovl_active = 1'($urandom); enable = 1'($urandom);
        end
        chk("rst_out_r", out_r, 0);
        chk("rst_out_g", out_g, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_syncs", {out_de, out_hs, out_vs}, 0);
        chk("rst_fade", fade_level, 0);
        chk("rst_busy", fade_busy, 0);

        // release with overlay off: pure passthrough
        enable = 0; vid_vs = 0; vid_hs = 0; vid_de = 1; ovl_active = 1;
        vid_r = 8'h5A; vid_g = 8'hA5; vid_b = 8'h3C;
        ovl_r = 8'hFF; ovl_g = 8'hFF; ovl_b = 8'hFF; ovl_alpha = 8'hFF;
        rst_n = 1'b1;
        tick(6);
        chk("pass_r", out_r, 8'h5A);
        chk("pass_g", out_g, 8'hA5);
        chk("pass_b", out_b, 8'h3C);
        chk("pass_de", out_de, 1);

        // fade-in ramp
        enable = 1;
        for (int i = 1; i <= 16; i++) begin
            vs_edge();
            chk($sformatf("fin_lvl%0d", i), fade_level, 32'(i * 16));
            chk($sformatf("fin_busy%0d", i), fade_busy, (i < 16) ? 1 : 0);
        end

        // blends at full fade
        blend("bl_opaque", 8'h00, 8'hFF, 8'hFF, 8'hFF);
        blend("bl_half",   8'h00, 8'hFF, 8'h80, 8'h80);  // 255*129+128 = 33023 -> 0x80
        blend("bl_mix",    8'h40, 8'hC0, 8'h80, 8'h81);  // 192*129+64*127+128 = 33024 -> 0x81
        blend("bl_clear",  8'h40, 8'hC0, 8'h00, 8'h40);

        // latency: single-cycle de/hs pulse
        vid_de = 0; vid_hs = 0;
        tick(6);
        vid_de = 1; vid_hs = 1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n == 1) begin vid_de = 0; vid_hs = 0; end
            chk($sformatf("lat1_de_%0d", n), out_de, (n == 4) ? 1 : 0);
            chk($sformatf("lat1_hs_%0d", n), out_hs, (n == 4) ? 1 : 0);
            chk($sformatf("lat0_de_%0d", n), z_de, (n == 3) ? 1 : 0);
        end

        // fade out fully, then check enable changes between edges are ignored
        enable = 0;
        for (int i = 1; i <= 16; i++) vs_edge();
        chk("fout_lvl", fade_level, 0);
        chk("fout_busy", fade_busy, 0);
        enable = 1; tick(3); enable = 0; tick(3);
        chk("noedge_lvl", fade_level, 0);

        // reversal mid-ramp
        enable = 1;
        for (int i = 1; i <= 6; i++) vs_edge();
        chk("rev_96", fade_level, 96);
        chk("rev_busy_in", fade_busy, 1);
        enable = 0;
        vs_edge();
        chk("rev_80", fade_level, 80);
        chk("rev_busy_out", fade_busy, 1);
        for (int i = 1; i <= 5; i++) begin
            vs_edge();
            chk($sformatf("rev_dn%0d", i), fade_level, 32'(80 - i * 16));
        end
        chk("rev_busy_end", fade_busy, 0);

        // gating at full fade
        enable = 1;
        for (int i = 1; i <= 16; i++) vs_edge();
        chk("gate_lvl", fade_level, 256);
        vid_de = 1; ovl_active = 0;
        blend("gate_inactive", 8'h33, 8'hEE, 8'hFF, 8'h33);
        ovl_active = 1; vid_de = 0;
        blend("gate_blank", 8'h33, 8'hEE, 8'hFF, 8'h00);
        chk("gate_blank_de", out_de, 0);

        // reset mid-fade aborts immediately
        vid_de = 1; enable = 0;
        for (int i = 1; i <= 8; i++) vs_edge();
        chk("mid_lvl", fade_level, 128);
        chk("mid_busy", fade_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lvl", fade_level, 0);
        chk("arst_busy", fade_busy, 0);
        chk("arst_de", out_de, 0);
        chk("arst_r", out_r, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
